// File: rtl/sha_access_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core among NUM_REQ requesters, with ownership locked per session.
// Optional grantee-inactivity timeout with lockout when SHA_ARB_TIMEOUT_EN is defined.
module sha_access_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int OWNER_W  = $clog2(NUM_REQ),
   parameter int MAX_HOLD = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*512-1:0]   req_block,
   input  logic [NUM_REQ-1:0]       req_init,
   input  logic [NUM_REQ-1:0]       req_next,
   input  logic [NUM_REQ-1:0]       req_sel,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [OWNER_W-1:0]       owner,
   output logic                     busy,
   output logic [511:0]             sha_block,
   output logic                     sha_init,
   output logic                     sha_next,
   output logic                     sha_sel,
   input  logic                     sha_ready,
   input  logic                     sha_digest_valid,
   input  logic [255:0]             sha_digest,
   output logic [NUM_REQ-1:0]       rsp_ready,
   output logic [NUM_REQ-1:0]       rsp_digest_valid,
   output logic [NUM_REQ*256-1:0]   rsp_digest,
   output logic                     timeout_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
   logic               busy_q, busy_d;

   logic [NUM_REQ-1:0] lockout;
   logic [NUM_REQ-1:0] eligible;
   logic               pick_valid;
   logic [OWNER_W-1:0] pick_idx;
   logic [OWNER_W-1:0] owner_inc;
   logic               in_grant;
   logic               own_req, own_init, own_next, own_sel;
   logic               force_rel;

   assign in_grant  = (state_q == ST_GRANT);
   assign own_req   = req[owner_q];
   assign own_init  = req_init[owner_q];
   assign own_next  = req_next[owner_q];
   assign own_sel   = req_sel[owner_q];
   assign eligible  = req & ~lockout;
   assign owner_inc = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);

   // Scan downward in offset so the lowest offset from rr_ptr wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         int idx;
         idx = (int'(rr_ptr_q) + j) % NUM_REQ;
         if (eligible[idx]) begin
            pick_valid = 1'b1;
            pick_idx   = OWNER_W'(idx);
         end
      end
   end

`ifdef SHA_ARB_TIMEOUT_EN
   localparam logic [12:0] HOLD_LAST = 13'(MAX_HOLD - 1);

   logic [12:0]        hold_q, hold_d;
   logic [NUM_REQ-1:0] lockout_q, lockout_d;
   logic               timeout_q, timeout_d;

   assign force_rel   = in_grant & own_req & (hold_q == HOLD_LAST);
   assign lockout     = lockout_q;
   assign timeout_err = timeout_q;

   always_comb begin
      hold_d = hold_q;
      if (!in_grant) begin
         hold_d = '0;
      end else if (own_init || own_next) begin
         hold_d = '0;
      end else begin
         hold_d = hold_q + 13'd1;
      end
      // Lockout persists only while the offender keeps its request raised.
      lockout_d = lockout_q & req;
      if (force_rel) begin
         lockout_d[owner_q] = 1'b1;
      end
      timeout_d = force_rel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q    <= '0;
         lockout_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         lockout_q <= lockout_d;
         timeout_q <= timeout_d;
      end
   end
`else
   assign force_rel   = 1'b0;
   assign lockout     = '0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            gnt_d   = '0;
            owner_d = '0;
            if (pick_valid) begin
               state_d = ST_GRANT;
               gnt_d   = NUM_REQ'(1) << pick_idx;
               owner_d = pick_idx;
            end
         end
         ST_GRANT: begin
            if (!own_req || force_rel) begin
               gnt_d = '0;
               if (sha_ready) begin
                  state_d  = ST_IDLE;
                  owner_d  = '0;
                  rr_ptr_d = owner_inc;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            gnt_d = '0;
            if (sha_ready) begin
               state_d  = ST_IDLE;
               owner_d  = '0;
               rr_ptr_d = owner_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            owner_d = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign busy  = busy_q;

   // Command path follows state_q, so it collapses to zero as soon as reset hits.
   assign sha_block = in_grant ? req_block[owner_q*512 +: 512] : '0;
   assign sha_init  = in_grant & own_init;
   assign sha_next  = in_grant & own_next;
   assign sha_sel   = in_grant & own_sel;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_ready[gi]             = gnt_q[gi] & sha_ready;
      assign rsp_digest_valid[gi]      = gnt_q[gi] & sha_digest_valid;
      assign rsp_digest[gi*256 +: 256] = gnt_q[gi] ? sha_digest : '0;
   end

endmodule
